// File: rtl/c1541_sd_arb_pkg.sv
// Shared types for the c1541 SD arbiter: state encoding and per-drive slice widths.
// Also used by the IEC bus multiplexer, which reuses the round-robin picker.
package c1541_sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    localparam int LBA_W  = 32;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1 with wrap.
// Zero latency; no backpressure, valid is low when nothing requests.
module c1541_rr_pick #(
    parameter int NDRV = 2,
    parameter int IW   = 2
) (
    input  logic [NDRV-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [2**IW-1:0] req_pad;
    logic [IW-1:0]    cand;

    always_comb begin
        req_pad            = '0;
        req_pad[NDRV-1:0]  = req;
        cand               = '0;
        idx                = '0;
        valid              = 1'b0;
        // Offset NDRV revisits the last winner, so a lone requester is still served.
        for (int k = 1; k <= NDRV; k++) begin
            cand = IW'((int'(last) + k) % NDRV);
            if (!valid && req_pad[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/c1541_sd_arb.sv
// Round-robin mux of up to four c1541_sd block interfaces onto one host SD port.
// Grant one cycle after request; the grant is held until the host ack ends (host paces the transfer).
module c1541_sd_arb
    import c1541_sd_arb_pkg::*;
#(
    parameter int NDRV = 2,
    parameter int IW   = 2
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [LBA_W*NDRV-1:0]   drv_sd_lba,
    input  logic [NDRV-1:0]         drv_sd_rd,
    input  logic [NDRV-1:0]         drv_sd_wr,
    output logic [NDRV-1:0]         drv_sd_ack,
    output logic [NDRV-1:0]         drv_sd_buff_wr,
    input  logic [BYTE_W*NDRV-1:0]  drv_sd_buff_din,
    output logic [LBA_W-1:0]        sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic [8:0]              sd_buff_addr,
    input  logic                    sd_buff_wr,
    output logic [BYTE_W-1:0]       sd_buff_din,
    output logic [IW-1:0]           grant_idx,
    output logic                    busy
);

    localparam int NSLOT = 2**IW;

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic [NDRV-1:0]    ack_q, ack_d;

    logic [NDRV-1:0]    req;
    logic [NSLOT-1:0]   rd_pad, wr_pad;
    logic [LBA_W-1:0]   lba_arr [NSLOT];
    logic [BYTE_W-1:0]  din_arr [NSLOT];
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic               gnt_req;
    logic               addr_unused;

    // The buffer address reaches the drives outside this block.
    assign addr_unused = ^sd_buff_addr;

    assign req = drv_sd_rd | drv_sd_wr;

    // Unpack per-drive slices into arrays padded to the index range.
    always_comb begin
        rd_pad            = '0;
        wr_pad            = '0;
        rd_pad[NDRV-1:0]  = drv_sd_rd;
        wr_pad[NDRV-1:0]  = drv_sd_wr;
        for (int i = 0; i < NSLOT; i++) begin
            lba_arr[i] = '0;
            din_arr[i] = '0;
        end
        for (int i = 0; i < NDRV; i++) begin
            lba_arr[i] = drv_sd_lba[i*LBA_W +: LBA_W];
            din_arr[i] = drv_sd_buff_din[i*BYTE_W +: BYTE_W];
        end
    end

    assign gnt_req = rd_pad[grant_q] | wr_pad[grant_q];

    c1541_rr_pick #(
        .NDRV (NDRV),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_REQ;
                    grant_d = pick_idx;
                    lba_d   = lba_arr[pick_idx];
                    rd_d    = rd_pad[pick_idx];
                    wr_d    = wr_pad[pick_idx];
                    busy_d  = 1'b1;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    // Host has taken the command; drop it so it is not re-issued.
                    state_d = ST_XFER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    for (int i = 0; i < NDRV; i++) begin
                        ack_d[i] = (grant_q == IW'(i));
                    end
                end else if (!gnt_req) begin
                    state_d = ST_IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = grant_q;
                end
            end
            ST_XFER: begin
                for (int i = 0; i < NDRV; i++) begin
                    ack_d[i] = sd_ack && (grant_q == IW'(i));
                end
                if (!sd_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = grant_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    // Buffer data path is live only during XFER; stray host strobes elsewhere are dropped.
    always_comb begin
        drv_sd_buff_wr = '0;
        sd_buff_din    = '0;
        if (state_q == ST_XFER) begin
            sd_buff_din = din_arr[grant_q];
            for (int i = 0; i < NDRV; i++) begin
                drv_sd_buff_wr[i] = sd_buff_wr && (grant_q == IW'(i));
            end
        end
    end

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign drv_sd_ack = ack_q;
    assign grant_idx  = grant_q;
    assign busy       = busy_q;

endmodule

// File: doc/c1541_sd_arb.md
Name: c1541_sd_arb

Overview:
- Multiplexes the block-level SD interfaces of up to four c1541_sd drive instances onto the single host SD port on clk_sys.
- Sits directly downstream of c1541_sd's sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* pins.
- Grants one drive per transfer with round-robin fairness and holds the grant until the host completes the transfer.
- Routes host buffer-write strobes to the granted drive only, and selects that drive's read-back data for the host.

Parameters:
- NDRV, 2, number of attached drives (1..4).
- IW, 2, width of the drive index; must satisfy 2**IW >= NDRV.

Ports:
- clk_sys  in  1  system clock; all logic is on this edge.
- reset  in  1  asynchronous, active-high reset.
- drv_sd_lba  in  32*NDRV  per-drive LBA; drive i occupies bits [32i+31:32i].
- drv_sd_rd  in  NDRV  per-drive read request (level).
- drv_sd_wr  in  NDRV  per-drive write request (level).
- drv_sd_ack  out  NDRV  per-drive ack; only the granted bit follows sd_ack.
- drv_sd_buff_wr  out  NDRV  per-drive buffer write strobe.
- drv_sd_buff_din  in  8*NDRV  per-drive read-back byte for host writes.
- sd_lba  out  32  host LBA.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host ack; high for the whole transfer.
- sd_buff_addr  in  9  host buffer address; broadcast to drives externally.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  byte returned to host.
- grant_idx  out  IW  index of the granted drive.
- busy  out  1  high while any grant is held.

Behaviour:
- Reset: asynchronous and active-high, as already decided. The arbiter returns to IDLE. Reset values: sd_rd=0, sd_wr=0, sd_lba=0, drv_sd_ack=0, drv_sd_buff_wr=0, grant_idx=0, busy=0, round-robin pointer=0.
- Request of drive i: req[i] = drv_sd_rd[i] | drv_sd_wr[i].
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from (last_grant+1) mod NDRV, with wrap.
  - Register the chosen index as grant_idx.
  - Latch that drive's LBA, rd and wr into sd_lba, sd_rd and sd_wr.
  - Set busy=1 and go to REQ.
  - Latency: request visible at edge N gives host sd_rd/sd_wr high after edge N+1.
- REQ:
  - Host outputs hold their latched values; LBA is never re-sampled mid-transfer.
  - sd_ack=1: go to XFER.
  - Granted req drops before sd_ack: cancel. Clear sd_rd/sd_wr, go to IDLE next cycle, advance last_grant.
- XFER:
  - drv_sd_ack[grant_idx] = sd_ack (registered, one-cycle delay). All other ack bits stay 0.
  - drv_sd_buff_wr[grant_idx] = sd_buff_wr, combinational, zero latency. Other bits stay 0.
  - sd_buff_din = drv_sd_buff_din[grant_idx] byte, combinational mux.
  - sd_rd/sd_wr clear on the first cycle of XFER; the host has accepted the command.
  - sd_ack falling: go to DONE.
- DONE:
  - Drop drv_sd_ack.
  - Set last_grant = grant_idx.
  - Go to IDLE.
  - busy drops on exit from DONE.
- Turnaround: minimum one IDLE cycle between transfers.
- Fairness: a requester re-asserting immediately after its own transfer yields to any other pending requester.
- drv_sd_rd and drv_sd_wr both high on one drive: both are forwarded unchanged. The host defines priority.
- Requests from drives at index >= NDRV are ignored.
- Outside XFER: sd_buff_din = 0 and all drv_sd_buff_wr = 0. Stray host writes are discarded.
- Reset during XFER: all outputs clear immediately (asynchronous). The drive's own ack-timeout recovery applies.

Decomposition:
- Shared package: state encoding (IDLE=0, REQ=1, XFER=2, DONE=3) and the per-drive slice widths (LBA_W=32, BYTE_W=8).
- One sub-module, c1541_rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: req[NDRV-1:0] and last[IW-1:0].
  - Outputs: idx[IW-1:0] and valid.
- Reused by the IEC bus multiplexer.

Test Plan:
- Single request: drive1 rd with LBA 0x0000_02A8 -> sd_lba=0x2A8 and sd_rd=1 one cycle later. Host acks 512 cycles with 2 writes -> drv_sd_buff_wr[1] pulses twice, bit0 stays 0, drv_sd_ack=2'b10.
- Simultaneous: drive0 and drive1 both request with last_grant=0 -> drive1 is served first, then drive0. grant_idx sequence is 1, 0.
- Write path: drive0 wr with drv_sd_buff_din slice0=0x5A, slice1=0xC3 -> sd_buff_din=0x5A throughout XFER and 0x00 after DONE.
- Cancel: drive1 drops rd before sd_ack -> sd_rd=0 within 2 cycles, busy=0, no ack pulse is ever issued.
- Reset mid-XFER: assert reset while sd_ack=1 -> sd_rd, sd_wr, drv_sd_ack and busy are 0 in the same cycle (async). After release, a new request is granted normally.
- Starvation: drive0 re-requests continuously while drive1 requests -> grants alternate 0, 1, 0, 1 over 4 transfers.
